// File: rtl/uart_baud_gen.sv
// Baud-tick generator for the UART TX/RX datapaths: fractional prescalers,
// RX oversample/mid-bit strobes, and deferred divisor updates while running.

module uart_baud_prescaler #(
  parameter int unsigned DIV_W  = 16,
  parameter int unsigned FRAC_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic              restart,
  input  logic [DIV_W-1:0]  p_int,
  input  logic [FRAC_W-1:0] p_frac,
  output logic              wrap
);

  logic              running;
  logic [DIV_W-1:0]  cnt;
  logic [FRAC_W-1:0] acc;
  logic [FRAC_W:0]   sum;
  logic [DIV_W-1:0]  term;

  // A carry out of the accumulator stretches the current period by one cycle.
  always_comb begin
    sum  = {1'b0, acc} + {1'b0, p_frac};
    term = sum[FRAC_W] ? p_int : p_int - DIV_W'(1);
    wrap = run && running && !restart && (cnt == term);
  end

  // The first enabled edge only arms the counter, so period n ends T1+..+Tn
  // edges after the enable (or restart) edge.
  always_ff @(posedge clock) begin
    if (reset || !run) begin
      running <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
    end else if (restart) begin
      running <= 1'b1;
      cnt     <= '0;
      acc     <= '0;
    end else if (!running) begin
      running <= 1'b1;
    end else if (wrap) begin
      cnt <= '0;
      acc <= sum[FRAC_W-1:0];
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

module uart_baud_gen #(
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned FRAC_W      = 4,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned DEFAULT_DIV = 27
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              cfg_load,
  input  logic              tx_en,
  input  logic              rx_en,
  input  logic              rx_resync,
  output logic              tx_tick,
  output logic              rx_os_tick,
  output logic              rx_sample_tick,
  output logic              cfg_pending
);

  localparam int unsigned OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);

  if (OVERSAMPLE < 4 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_os
    $error("uart_baud_gen: OVERSAMPLE must be a power of two >= 4");
  end

  typedef enum logic {
    CFG_IDLE,
    CFG_PEND
  } cfg_state_t;

  cfg_state_t        cfg_state, cfg_next;
  logic [DIV_W-1:0]  act_int, pend_int, p_int;
  logic [FRAC_W-1:0] act_frac, pend_frac;
  logic              idle, act_load, act_from_pend, pend_load;
  logic              tx_wrap, rx_wrap;
  logic [OS_W-1:0]   tx_os_cnt, rx_phase;

  assign idle        = !tx_en && !rx_en;
  assign cfg_pending = (cfg_state == CFG_PEND);
  assign p_int       = (act_int < DIV_W'(2)) ? DIV_W'(2) : act_int;

  // Divisor update FSM: the active divisor only changes while both
  // generators are held, so no period ever changes mid-count.
  always_ff @(posedge clock) begin
    if (reset) cfg_state <= CFG_IDLE;
    else       cfg_state <= cfg_next;
  end

  always_comb begin
    cfg_next      = cfg_state;
    act_load      = 1'b0;
    act_from_pend = 1'b0;
    pend_load     = 1'b0;
    if (cfg_load && idle) begin
      act_load = 1'b1;
      cfg_next = CFG_IDLE;
    end else if (cfg_load) begin
      pend_load = 1'b1;
      cfg_next  = CFG_PEND;
    end else if (cfg_state == CFG_PEND && idle) begin
      act_load      = 1'b1;
      act_from_pend = 1'b1;
      cfg_next      = CFG_IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      act_int   <= DIV_W'(DEFAULT_DIV);
      act_frac  <= '0;
      pend_int  <= '0;
      pend_frac <= '0;
    end else begin
      if (pend_load) begin
        pend_int  <= div_int;
        pend_frac <= div_frac;
      end
      if (act_load) begin
        act_int  <= act_from_pend ? pend_int  : div_int;
        act_frac <= act_from_pend ? pend_frac : div_frac;
      end
    end
  end

  uart_baud_prescaler #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W)
  ) u_tx_pre (
    .clock   (clock),
    .reset   (reset),
    .run     (tx_en),
    .restart (1'b0),
    .p_int   (p_int),
    .p_frac  (act_frac),
    .wrap    (tx_wrap)
  );

  uart_baud_prescaler #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W)
  ) u_rx_pre (
    .clock   (clock),
    .reset   (reset),
    .run     (rx_en),
    .restart (rx_resync),
    .p_int   (p_int),
    .p_frac  (act_frac),
    .wrap    (rx_wrap)
  );

  always_ff @(posedge clock) begin
    if (reset || !tx_en) begin
      tx_os_cnt <= '0;
      tx_tick   <= 1'b0;
    end else begin
      tx_tick <= tx_wrap && (tx_os_cnt == OS_LAST);
      if (tx_wrap) tx_os_cnt <= tx_os_cnt + OS_W'(1);
    end
  end

  // Resync shares the disabled path; a coinciding tick is dropped.
  always_ff @(posedge clock) begin
    if (reset || !rx_en || rx_resync) begin
      rx_phase       <= '0;
      rx_os_tick     <= 1'b0;
      rx_sample_tick <= 1'b0;
    end else begin
      rx_os_tick     <= rx_wrap;
      rx_sample_tick <= rx_wrap && (rx_phase == OS_MID);
      if (rx_wrap) rx_phase <= rx_phase + OS_W'(1);
    end
  end

endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed self-checking bench for uart_baud_gen with default parameters.

module tb_uart_baud_gen;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic        cfg_load, tx_en, rx_en, rx_resync;
  logic        tx_tick, rx_os_tick, rx_sample_tick, cfg_pending;

  int tests = 0;
  int fails = 0;
  int n;

  uart_baud_gen #(
    .DIV_W       (16),
    .FRAC_W      (4),
    .OVERSAMPLE  (16),
    .DEFAULT_DIV (27)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .div_int        (div_int),
    .div_frac       (div_frac),
    .cfg_load       (cfg_load),
    .tx_en          (tx_en),
    .rx_en          (rx_en),
    .rx_resync      (rx_resync),
    .tx_tick        (tx_tick),
    .rx_os_tick     (rx_os_tick),
    .rx_sample_tick (rx_sample_tick),
    .cfg_pending    (cfg_pending)
  );

  always #5 clock = ~clock;

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick_edge();
    @(posedge clock);
    #1;
  endtask

  // Edges until the chosen tick is seen (0 tx, 1 rx_os, 2 rx_sample), bounded.
  task automatic next_tick(input int which, input int limit, output int cnt);
    logic seen;
    cnt = 0;
    do begin
      tick_edge();
      cnt++;
      case (which)
        0:       seen = tx_tick;
        1:       seen = rx_os_tick;
        default: seen = rx_sample_tick;
      endcase
    end while (!seen && cnt < limit);
  endtask

  task automatic load_idle(input int di, input int fr);
    tx_en    = 1'b0;
    rx_en    = 1'b0;
    div_int  = 16'(di);
    div_frac = 4'(fr);
    cfg_load = 1'b1;
    tick_edge();
    cfg_load = 1'b0;
    check(32'(cfg_pending), 0, "idle_load_no_pending");
  endtask

  initial begin
    reset = 1'b1; div_int = '0; div_frac = '0;
    cfg_load = 1'b0; tx_en = 1'b0; rx_en = 1'b0; rx_resync = 1'b0;
    repeat (2) tick_edge();
    check(32'(tx_tick), 0, "reset_tx_tick");
    check(32'(rx_os_tick), 0, "reset_rx_os_tick");
    check(32'(rx_sample_tick), 0, "reset_rx_sample");
    check(32'(cfg_pending), 0, "reset_pending");
    reset = 1'b0;

    // Default divisor 27
    rx_en = 1'b1;
    tick_edge();
    next_tick(1, 100, n); check(n, 27, "def_os_first");
    tick_edge();          check(32'(rx_os_tick), 0, "def_os_width");
    next_tick(1, 100, n); check(n, 26, "def_os_second");
    next_tick(1, 100, n); check(n, 27, "def_os_third");
    check(32'(tx_tick), 0, "tx_idle_quiet");
    rx_en = 1'b0;
    tick_edge();
    rx_en = 1'b1;
    tick_edge();
    next_tick(2, 1000, n); check(n, 216, "def_sample_first");
    check(32'(rx_os_tick), 1, "sample_with_os");
    next_tick(2, 1000, n); check(n, 432, "def_sample_second");

    // Fractional 4 + 8/16
    load_idle(4, 8);
    tx_en = 1'b1; rx_en = 1'b1;
    tick_edge();
    next_tick(1, 20, n); check(n, 4, "frac_os_1");
    next_tick(1, 20, n); check(n, 5, "frac_os_2");
    next_tick(1, 20, n); check(n, 4, "frac_os_3");
    next_tick(1, 20, n); check(n, 5, "frac_os_4");
    tx_en = 1'b0; rx_en = 1'b0;
    tick_edge();
    tx_en = 1'b1;
    tick_edge();
    next_tick(0, 200, n); check(n, 72, "frac_tx_first");
    next_tick(0, 200, n); check(n, 72, "frac_tx_second");

    // Clamp of 0 and 1 to 2
    load_idle(0, 0);
    rx_en = 1'b1;
    tick_edge();
    next_tick(1, 20, n); check(n, 2, "div0_os_1");
    next_tick(1, 20, n); check(n, 2, "div0_os_2");
    load_idle(1, 0);
    rx_en = 1'b1;
    tick_edge();
    next_tick(1, 20, n); check(n, 2, "div1_os_1");
    next_tick(1, 20, n); check(n, 2, "div1_os_2");

    // Deferred config while running; second load overwrites the first
    div_int = 16'd7; cfg_load = 1'b1;
    tick_edge();
    div_int = 16'd10;
    tick_edge();
    cfg_load = 1'b0;
    check(32'(rx_os_tick), 1, "pend_old_period_kept");
    check(32'(cfg_pending), 1, "pend_set");
    next_tick(1, 20, n); check(n, 2, "pend_old_period_next");
    check(32'(cfg_pending), 1, "pend_held");
    rx_en = 1'b0;
    tick_edge();
    check(32'(cfg_pending), 0, "pend_applied");
    rx_en = 1'b1;
    tick_edge();
    next_tick(1, 40, n); check(n, 10, "pend_new_period");

    // Resync
    load_idle(4, 0);
    rx_en = 1'b1;
    tick_edge();
    repeat (20) tick_edge();
    check(32'(rx_os_tick), 1, "resync_pre_tick20");
    rx_resync = 1'b1;
    tick_edge();
    rx_resync = 1'b0;
    next_tick(1, 20, n);  check(n, 4, "resync_os_25");
    next_tick(2, 100, n); check(n, 28, "resync_sample_53");
    repeat (3) tick_edge();
    rx_resync = 1'b1;
    tick_edge();
    rx_resync = 1'b0;
    check(32'(rx_os_tick), 0, "resync_beats_tick");
    next_tick(1, 20, n);  check(n, 4, "resync_after_coincide");

    // Reset mid-run with a pending config
    div_int = 16'd9; cfg_load = 1'b1;
    tick_edge();
    cfg_load = 1'b0;
    check(32'(cfg_pending), 1, "rst_pend_set");
    tx_en = 1'b1;
    reset = 1'b1;
    tick_edge();
    check(32'(tx_tick), 0, "rst_mid_tx");
    check(32'(rx_os_tick), 0, "rst_mid_os");
    check(32'(rx_sample_tick), 0, "rst_mid_sample");
    check(32'(cfg_pending), 0, "rst_mid_pending");
    reset = 1'b0;
    tx_en = 1'b0;
    tick_edge();
    next_tick(1, 100, n); check(n, 27, "rst_default_div");
    check(32'(cfg_pending), 0, "rst_pending_stays_clear");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
